// File: rtl/onchip_block_copier_if.sv
// Bus bundle for onchip_block_copier: Avalon-MM register slave plus the s2 memory port.
// The slave modport is the copier's view; master is the CPU/memory side.
interface onchip_block_copier_if #(
  parameter int ADDR_W = 11
);
  logic [2:0]        address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

  modport slave (
    input  address, chipselect, write, read, writedata, mem_readdata,
    output readdata, irq, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );

  modport master (
    output address, chipselect, write, read, writedata, mem_readdata,
    input  readdata, irq, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_block_copier.sv
// DMA copy/fill engine driving port s2 of the 2048x32 on-chip RAM.
// Software programs it through a small register file; a level irq reports completion.
module onchip_block_copier #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 12
) (
  input logic clk,
  input logic reset,
  onchip_block_copier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, FL} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t            state, state_next;
  logic [ADDR_W-1:0] src_reg, dst_reg, cur_src, cur_dst;
  logic [LEN_W-1:0]  len_reg, remaining, len_in;
  logic [31:0]       fill_reg;
  logic              irq_en, done, aborted;
  logic              busy, reg_wr, go, abort_req, last_word;

  assign busy      = (state != IDLE);
  assign reg_wr    = bus.chipselect & bus.write;
  assign go        = reg_wr && (bus.address == 3'd4) && bus.writedata[0] && !busy;
  assign abort_req = reg_wr && (bus.address == 3'd4) && bus.writedata[3] && busy;
  assign last_word = (remaining == LEN_W'(1));
  assign len_in    = (bus.writedata[LEN_W-1:0] > MAX_LEN) ? MAX_LEN : bus.writedata[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Copy alternates RD/WR because the RAM returns read data one cycle after the address.
  always_comb begin
    state_next         = state;
    bus.mem_chipselect = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_writedata  = '0;
    case (state)
      IDLE: begin
        if (go && (len_reg != '0)) state_next = bus.writedata[1] ? FL : RD;
      end
      RD: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_address    = cur_src;
        state_next         = abort_req ? IDLE : WR;
      end
      WR: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = cur_dst;
        bus.mem_writedata  = bus.mem_readdata;
        state_next         = (abort_req || last_word) ? IDLE : RD;
      end
      FL: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = cur_dst;
        bus.mem_writedata  = fill_reg;
        state_next         = (abort_req || last_word) ? IDLE : FL;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;

  // Flag updates follow the done-clear so a completion in the same cycle keeps done set.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      fill_reg  <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      if (reg_wr && !busy) begin
        case (bus.address)
          3'd0:    src_reg  <= bus.writedata[ADDR_W-1:0];
          3'd1:    dst_reg  <= bus.writedata[ADDR_W-1:0];
          3'd2:    len_reg  <= len_in;
          3'd3:    fill_reg <= bus.writedata;
          default: ;
        endcase
      end
      if (reg_wr && (bus.address == 3'd4)) irq_en <= bus.writedata[2];
      if (reg_wr && (bus.address == 3'd5) && bus.writedata[1]) begin
        done    <= 1'b0;
        aborted <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (go) begin
            cur_src   <= src_reg;
            cur_dst   <= dst_reg;
            remaining <= len_reg;
            done      <= (len_reg == '0);
            aborted   <= 1'b0;
          end
        end
        RD: begin
          if (abort_req) begin
            done    <= 1'b1;
            aborted <= 1'b1;
          end
        end
        WR, FL: begin
          cur_dst   <= cur_dst + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
          if (state == WR) cur_src <= cur_src + ADDR_W'(1);
          if (abort_req || last_word) done <= 1'b1;
          if (abort_req) aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect && bus.read) begin
      case (bus.address)
        3'd0:    bus.readdata = 32'(src_reg);
        3'd1:    bus.readdata = 32'(dst_reg);
        3'd2:    bus.readdata = 32'(len_reg);
        3'd3:    bus.readdata = fill_reg;
        3'd4:    bus.readdata = {29'd0, irq_en, 2'b00};
        3'd5:    bus.readdata = (32'(remaining) << 16) | {29'd0, aborted, done, busy};
        default: bus.readdata = '0;
      endcase
    end
  end

  assign bus.irq = done & irq_en;
endmodule

// File: tb/tb_onchip_block_copier.sv
// Randomized bench for onchip_block_copier: a behavioural RAM on port s2 plus a
// word-level reference memory that applies each copy/fill as a plain ascending loop.
module tb_onchip_block_copier;
  logic clk = 1'b0;
  logic reset;

  onchip_block_copier_if bus ();

  onchip_block_copier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [0:2047];
  logic [31:0] refMem [0:2047];
  logic [31:0] rdataQ = 32'd0;
  int          wlog[$];
  int          rlog[$];
  int          tests = 0;
  int          fails = 0;

  assign bus.mem_readdata = rdataQ;

  // Synchronous RAM with one cycle read latency; every access is logged in order.
  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken) begin
      rdataQ <= mem[bus.mem_address];
      if (bus.mem_write) begin
        mem[bus.mem_address] = bus.mem_writedata;
        wlog.push_back(int'(bus.mem_address));
      end else begin
        rlog.push_back(int'(bus.mem_address));
      end
    end
  end

  function automatic logic [10:0] wrapAddr(input int a);
    return 11'(a % 2048);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic regWrite(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic regRead(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    #1;
    d              = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int cycles);
    logic [31:0] st;
    cycles = 0;
    regRead(3'd5, st);
    while (st[0] && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      regRead(3'd5, st);
    end
    checkOutput("idle_within_budget", 32'(st[0]), 32'd0);
  endtask

  task automatic memCompare(input string tag);
    int bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== refMem[i]) bad++;
    checkOutput({tag, "_mem"}, bad, 0);
  endtask

  task automatic randomizeMem();
    for (int i = 0; i < 2048; i++) begin
      mem[i]    = $urandom;
      refMem[i] = mem[i];
    end
  endtask

  // One complete transfer: program, go, wait, then compare against the reference model.
  task automatic applyStimulus(input string tag, input bit fillMode, input bit irqEn,
                               input int src, input int dst, input int len, input logic [31:0] pattern);
    int          cycles, n, bad;
    logic [31:0] st;
    n = (len > 2048) ? 2048 : len;
    regWrite(3'd0, 32'(src));
    regWrite(3'd1, 32'(dst));
    regWrite(3'd2, 32'(len));
    regWrite(3'd3, pattern);
    wlog.delete();
    rlog.delete();
    regWrite(3'd4, {28'd0, 1'b0, irqEn, fillMode, 1'b1});
    waitIdle(5000, cycles);
    checkOutput({tag, "_cycles"}, cycles, fillMode ? n : 2 * n);
    for (int i = 0; i < n; i++) begin
      if (fillMode) refMem[wrapAddr(dst + i)] = pattern;
      else          refMem[wrapAddr(dst + i)] = refMem[wrapAddr(src + i)];
    end
    memCompare(tag);
    bad = (wlog.size() != n) ? 1 : 0;
    for (int i = 0; i < wlog.size() && i < n; i++) if (wlog[i] != dst % 2048 + 0 && wlog[i] != int'(wrapAddr(dst + i))) bad++;
    for (int i = 0; i < wlog.size() && i < n; i++) if (wlog[i] != int'(wrapAddr(dst + i))) bad++;
    checkOutput({tag, "_write_order"}, bad, 0);
    bad = (rlog.size() != (fillMode ? 0 : n)) ? 1 : 0;
    for (int i = 0; i < rlog.size() && i < n; i++) if (rlog[i] != int'(wrapAddr(src + i))) bad++;
    checkOutput({tag, "_read_order"}, bad, 0);
    regRead(3'd5, st);
    checkOutput({tag, "_status"}, st, 32'h2);
    checkOutput({tag, "_irq"}, 32'(bus.irq), 32'(irqEn));
    regWrite(3'd5, 32'h2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          cycles;
    int          wc;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.writedata  = 32'd0;
    reset          = 1'b1;
    randomizeMem();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    regRead(3'd5, d);
    checkOutput("rst_status", d, 32'd0);
    checkOutput("rst_irq", 32'(bus.irq), 32'd0);
    checkOutput("rst_mem_cs_we", 32'({bus.mem_chipselect, bus.mem_write}), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    checkOutput("rst_mem_wdata", bus.mem_writedata, 32'd0);
    checkOutput("rst_be_clken", 32'({bus.mem_byteenable, bus.mem_clken}), 32'h1F);

    regWrite(3'd0, 32'hFFFF_FFFF);
    regRead(3'd0, d);
    checkOutput("src_mask", d, 32'h7FF);
    regWrite(3'd2, 32'h0000_0FFF);
    regRead(3'd2, d);
    checkOutput("len_clamp", d, 32'd2048);
    regWrite(3'd2, 32'hFFFF_07FF);
    regRead(3'd2, d);
    checkOutput("len_mask", d, 32'h7FF);
    regRead(3'd6, d);
    checkOutput("unused_addr", d, 32'd0);

    applyStimulus("fill", 1'b1, 1'b1, 0, 'h100, 16, 32'hDEAD_BEEF);

    for (int i = 0; i < 8; i++) begin
      mem[i]    = 32'(i);
      refMem[i] = 32'(i);
    end
    applyStimulus("copy", 1'b0, 1'b1, 0, 'h400, 8, 32'd0);
    applyStimulus("wrap", 1'b0, 1'b0, 'h7FE, 'h010, 4, 32'd0);

    mem[0]    = 32'hA5A5_0001;
    refMem[0] = 32'hA5A5_0001;
    applyStimulus("overlap", 1'b0, 1'b1, 0, 1, 4, 32'd0);
    checkOutput("overlap_last", mem[4], 32'hA5A5_0001);

    applyStimulus("len0", 1'b0, 1'b1, 5, 9, 0, 32'd0);
    applyStimulus("clamp", 1'b1, 1'b0, 0, 'h300, 4095, 32'h0F0F_1234);
    randomizeMem();

    for (int k = 0; k < 8; k++) begin
      applyStimulus($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(1, 48)), $urandom);
    end

    // A second go while busy must not restart or reprogram the running fill.
    regWrite(3'd1, 32'h200);
    regWrite(3'd2, 32'd20);
    regWrite(3'd3, 32'h1234_5678);
    wlog.delete();
    regWrite(3'd4, 32'h3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    regWrite(3'd2, 32'd5);
    regWrite(3'd3, 32'hFFFF_0000);
    regWrite(3'd4, 32'h1);
    waitIdle(100, cycles);
    checkOutput("busygo_cycles", cycles + 6, 32'd20);
    regRead(3'd2, d);
    checkOutput("busygo_len", d, 32'd20);
    checkOutput("busygo_writes", wlog.size(), 32'd20);
    for (int i = 0; i < 20; i++) refMem['h200 + i] = 32'h1234_5678;
    memCompare("busygo");
    regWrite(3'd5, 32'h2);

    // Abort a 100-word fill during its 10th write cycle.
    regWrite(3'd1, 32'h500);
    regWrite(3'd2, 32'd100);
    regWrite(3'd3, 32'hCAFE_F00D);
    wlog.delete();
    regWrite(3'd4, 32'h7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    regWrite(3'd4, 32'hC);
    regRead(3'd5, d);
    checkOutput("abort_status", d, {4'd0, 12'd90, 13'd0, 3'b110});
    checkOutput("abort_irq", 32'(bus.irq), 32'd1);
    checkOutput("abort_writes", wlog.size(), 32'd10);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_no_more", wlog.size(), 32'd10);
    for (int i = 0; i < 10; i++) refMem['h500 + i] = 32'hCAFE_F00D;
    memCompare("abort");
    regWrite(3'd5, 32'h2);
    regRead(3'd5, d);
    checkOutput("abort_clear", d, {4'd0, 12'd90, 16'd0});
    checkOutput("abort_clear_irq", 32'(bus.irq), 32'd0);

    // Reset in the middle of a copy: writes land on edges E0+2,4,6,8 then stop.
    regWrite(3'd0, 32'h600);
    regWrite(3'd1, 32'h700);
    regWrite(3'd2, 32'd50);
    wlog.delete();
    regWrite(3'd4, 32'h5);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstmid_mem_cs_we", 32'({bus.mem_chipselect, bus.mem_write}), 32'd0);
    checkOutput("rstmid_mem_addr", 32'(bus.mem_address), 32'd0);
    checkOutput("rstmid_irq", 32'(bus.irq), 32'd0);
    regRead(3'd5, d);
    checkOutput("rstmid_status", d, 32'd0);
    wc = wlog.size();
    checkOutput("rstmid_writes", wc, 32'd4);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rstmid_stop", wlog.size(), 32'd4);
    for (int i = 0; i < 4; i++) refMem['h700 + i] = refMem['h600 + i];
    memCompare("rstmid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/onchip_block_copier.md
# onchip_block_copier

DMA-style copy/fill engine that owns the second port (s2) of the 2048×32 dual-port on-chip memory, while the Nios II CPU keeps port s1. The OS uses it to copy thread stacks and contexts, and to clear or fill memory regions, without spending CPU cycles. Software programs it through a small Avalon-MM slave register file. The engine then drives port s2 with word-wide accesses and raises an interrupt on completion.

## Interface
- ADDR_W, 11: word address width of the memory port (2048 words).
- LEN_W, 12: length counter width (0..2048 words).
- clk  in  1  single clock; also drives memory clk2.
- reset  in  1  synchronous, active-high.
- address  in  3  register select: 0 SRC, 1 DST, 2 LEN, 3 FILL, 4 CTRL, 5 STATUS.
- chipselect  in  1  slave select.
- write  in  1  register write strobe.
- read  in  1  register read strobe.
- writedata  in  32  register write data.
- readdata  out  32  register read data, combinational (zero-wait).
- irq  out  1  level interrupt = done & irq_en.
- mem_address  out  11  to address2.
- mem_byteenable  out  4  to byteenable2; constant 4'hF.
- mem_chipselect  out  1  to chipselect2.
- mem_write  out  1  to write2.
- mem_writedata  out  32  to writedata2.
- mem_clken  out  1  to clken2; constant 1.
- mem_readdata  in  32  from readdata2; valid in the cycle after the address is presented (1-cycle latency).

## Operation
- Registers:
  - SRC[10:0] and DST[10:0] are word addresses.
  - LEN[11:0] is the word count; values above 2048 are clamped to 2048.
  - FILL[31:0] is the fill pattern.
- CTRL write bits:
  - bit0 go.
  - bit1 mode (0 copy, 1 fill).
  - bit2 irq_en (stored).
  - bit3 abort.
- STATUS read: bit0 busy, bit1 done, bit2 aborted, bits[27:16] words remaining.
- STATUS write: writing 1 to bit1 clears done and aborted.
- Reads of unused addresses, and of the unused bits of SRC/DST/LEN, return 0.
- While busy, writes to SRC, DST, LEN and FILL are ignored, and go is ignored. abort and irq_en are honoured.
- States:
  - IDLE: on go with LEN≠0, latch src/dst/remaining and go to RD (copy) or FL (fill). On go with LEN=0, set done without any memory access.
  - RD: mem_chipselect=1, mem_write=0, mem_address=src. Next state WR.
  - WR: mem_chipselect=1, mem_write=1, mem_address=dst, mem_writedata=mem_readdata. Then src+1, dst+1, remaining−1. If remaining becomes 0, go to IDLE and set done; otherwise go to RD.
  - FL: mem_chipselect=1, mem_write=1, mem_address=dst, mem_writedata=FILL. Then dst+1, remaining−1. If remaining becomes 0, go to IDLE and set done.
- Copy order is always ascending.
  - Overlapping regions with DST>SRC propagate data; this is the defined behaviour and is not an error.
- Addresses wrap modulo 2048 (11-bit arithmetic): 2047+1 → 0.
- Abort while busy:
  - The current cycle's access completes if it is a write. A pending RD is dropped.
  - State returns to IDLE on the next edge; done=1, aborted=1.
  - Remaining holds the count of words not written.
- A go and a STATUS done-clear on the same write are impossible because they are different addresses. A done-clear in the same cycle that done sets leaves done set.
- Reset (any state): state IDLE, all registers 0, busy=done=aborted=irq_en=0. All outputs go to their reset values on the next edge.

## Timing
- Reset values:
  - readdata=0, irq=0.
  - mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0.
  - mem_byteenable=4'hF, mem_clken=1.
- go is written at edge E0. busy=1 from E0+ onward.
- Copy of N words: memory activity occupies exactly 2N cycles. The last write is captured at edge E0+2N; busy=0 and done=1 immediately after that edge.
- Fill of N words: N cycles, one write per cycle; done after edge E0+N.
- LEN=0: done=1 after E0 and busy never asserts.
- irq follows done the same cycle, combinationally from registered flags.

## Test plan
- Fill: FILL=0xDEADBEEF, DST=0x100, LEN=16, go with mode=1 → 16 consecutive writes to 0x100..0x10F, done after exactly 16 cycles, irq=1 when irq_en=1.
- Copy: preload 0x000..0x007 with 0..7; SRC=0, DST=0x400, LEN=8, go → 0x400..0x407 hold 0..7, busy for exactly 16 cycles.
- Wrap: SRC=0x7FE, DST=0x010, LEN=4 copy → reads 0x7FE, 0x7FF, 0x000, 0x001 in that order; no out-of-range address.
- Abort: fill LEN=100, abort on the 10th cycle → IDLE next edge, aborted=1, remaining=90, no further writes; STATUS write 0x2 clears done/aborted and irq.
- Edge cases: LEN=0 go → done next cycle with no memory access. Second go while busy → ignored and LEN unchanged. Overlap SRC=0, DST=1, LEN=4 with mem[0]=A → mem[1..4]=A.
- Reset mid-copy → outputs reset next edge, STATUS reads 0, memory writes stop.
